// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: stage k shifts by 2^k when shift bit k is set.
// A result is visible on oBits/oValid STAGES-1 edges after its accepting edge and is consumed on the STAGES-th.
module shift_pipe #(
  parameter int width = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iValid,
  output logic                     iReady,
  input  logic [width-1:0]         iBits,
  input  logic [$clog2(width)-1:0] shift,
  input  logic [1:0]               mode,
  output logic                     oValid,
  input  logic                     oReady,
  output logic [width-1:0]         oBits
);
  localparam int STAGES = $clog2(width);

  localparam logic [1:0] M_LSR = 2'b00;
  localparam logic [1:0] M_LSL = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;

  typedef struct packed {
    logic [width-1:0]  data;
    logic [1:0]        mode;
    logic [STAGES-1:0] shamt;
    logic              fill;
  } stage_t;

  stage_t            in_s;
  stage_t            stg [STAGES];
  logic [STAGES-1:0] vld;
  logic              adv;

  assign adv    = !oValid || oReady;
  assign iReady = rst && adv;
  assign oValid = vld[STAGES-1];
  assign oBits  = stg[STAGES-1].data;

  always_comb begin
    in_s       = '0;
    in_s.data  = iBits;
    in_s.mode  = mode;
    in_s.shamt = shift;
    in_s.fill  = iBits[width-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int AMT = 1 << k;
    localparam logic [width-1:0] FILL_MSK = ~({width{1'b1}} >> AMT);

    stage_t src;
    stage_t nxt;
    stage_t st_q;
    logic   vin;
    logic   vld_q;

    if (k == 0) begin : g_head
      assign src = in_s;
      assign vin = iValid;
    end else begin : g_body
      assign src = stg[k-1];
      assign vin = vld[k-1];
    end

    always_comb begin
      nxt = src;
      if (src.shamt[k]) begin
        unique case (src.mode)
          M_LSR:   nxt.data = src.data >> AMT;
          M_LSL:   nxt.data = src.data << AMT;
          M_ASR:   nxt.data = (src.data >> AMT) | (src.fill ? FILL_MSK : '0);
          default: nxt.data = (src.data >> AMT) | (src.data << (width - AMT));
        endcase
      end
    end

    // The last stage only loads real results so oBits keeps its value across bubbles.
    always_ff @(posedge clk) begin
      if (!rst) begin
        st_q  <= '0;
        vld_q <= 1'b0;
      end else if (adv) begin
        vld_q <= vin;
        if (k != STAGES - 1 || vin) st_q <= nxt;
      end
    end

    assign stg[k] = st_q;
    assign vld[k] = vld_q;
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (width=8): directed vectors, stall, mid-reset and a random scoreboard run.
module tb_shift_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iValid = 1'b0;
  logic       oReady = 1'b0;
  logic [7:0] iBits = '0;
  logic [2:0] shift = '0;
  logic [1:0] mode = '0;
  logic       iReady;
  logic       oValid;
  logic [7:0] oBits;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  shift_pipe #(.width(8)) dut (
    .clk(clk), .rst(rst), .iValid(iValid), .iReady(iReady), .iBits(iBits),
    .shift(shift), .mode(mode), .oValid(oValid), .oReady(oReady), .oBits(oBits)
  );

  always #5 clk = ~clk;

  // Single-step reference: the whole shift in one go on an 8-bit value.
  function automatic logic [7:0] ref_op(input logic [7:0] x, input int s, input logic [1:0] m);
    logic [15:0] d;
    case (m)
      2'b00:   return x >> s;
      2'b01:   return 8'((16'(x) << s) & 16'h00FF);
      2'b10:   return 8'($signed(x) >>> s);
      default: begin d = {x, x} >> s; return d[7:0]; end
    endcase
  endfunction

  // Drive inputs on the falling edge and return what the DUT shows for the next rising edge.
  task automatic step(input logic v, input logic [7:0] b, input logic [2:0] s, input logic [1:0] m,
                      input logic ordy, output logic ir, output logic ov, output logic [7:0] ob);
    @(negedge clk);
    iValid = v; iBits = b; shift = s; mode = m; oReady = ordy;
    #1;
    ir = iReady; ov = oValid; ob = oBits;
  endtask

  task automatic test_reset;
    logic ir, ov;
    logic [7:0] ob;
    int nout;
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 8'h5A, 3'd1, 2'b01, 1'b1, ir, ov, ob);
      n_cmp++; if (ov !== 1'b0)  begin n_err++; $display("FAIL rst_ovalid c=%0d got=%b exp=0", c, ov); end
      n_cmp++; if (ob !== 8'h00) begin n_err++; $display("FAIL rst_obits c=%0d got=%h exp=00", c, ob); end
      n_cmp++; if (ir !== 1'b0)  begin n_err++; $display("FAIL rst_iready c=%0d got=%b exp=0", c, ir); end
    end
    // Release and offer (0x81, 0, 11) on the very first edge with rst=1.
    rst = 1'b1; iValid = 1'b1; iBits = 8'h81; shift = 3'd0; mode = 2'b11; oReady = 1'b1;
    #1;
    n_cmp++; if (iReady !== 1'b1) begin n_err++; $display("FAIL release_iready got=%b exp=1", iReady); end
    nout = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, ir, ov, ob);
      if (k == 3) begin
        n_cmp++; if (ov !== 1'b1)  begin n_err++; $display("FAIL latency_ovalid got=%b exp=1", ov); end
        n_cmp++; if (ob !== 8'h81) begin n_err++; $display("FAIL shift0_obits got=%h exp=81", ob); end
      end
      if (k == 4) begin
        n_cmp++; if (ob !== 8'h81) begin n_err++; $display("FAIL bubble_hold got=%h exp=81", ob); end
      end
      if (ov === 1'b1) nout++;
    end
    n_cmp++; if (nout != 1) begin n_err++; $display("FAIL reset_capture outputs=%0d exp=1", nout); end
  endtask

  task automatic test_vectors;
    logic [7:0] vb[7] = '{8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'h81, 8'h80, 8'h01};
    logic [2:0] vs[7] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd7, 3'd7};
    logic [1:0] vm[7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [7:0] ve[7] = '{8'h16, 8'hA0, 8'hF6, 8'h96, 8'h81, 8'hFF, 8'h02};
    logic ir, ov, v;
    logic [7:0] ob;
    int sent, got, first_acc, first_out, last_out;
    sent = 0; got = 0; first_acc = -1; first_out = -1; last_out = -1;
    for (int c = 0; c < 14; c++) begin
      v = (sent < 7);
      step(v, v ? vb[sent] : 8'h00, v ? vs[sent] : 3'd0, v ? vm[sent] : 2'b00, 1'b1, ir, ov, ob);
      if (ov && got < 7) begin
        n_cmp++;
        if (ob !== ve[got]) begin n_err++; $display("FAIL vector%0d got=%h exp=%h", got, ob, ve[got]); end
        if (first_out < 0) first_out = c;
        last_out = c;
        got++;
      end
      if (v && ir) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
    end
    n_cmp++; if (got != 7) begin n_err++; $display("FAIL vector_count got=%0d exp=7", got); end
    n_cmp++;
    if (first_out - first_acc != 3) begin
      n_err++; $display("FAIL vector_latency got=%0d exp=3", first_out - first_acc);
    end
    n_cmp++;
    if (last_out - first_out != 6) begin
      n_err++; $display("FAIL vector_throughput span=%0d exp=6", last_out - first_out);
    end
  endtask

  task automatic test_stall;
    logic ir, ov, ordy, prev_stall;
    logic [7:0] ob, prev_ob, cb;
    logic [2:0] cs;
    logic [1:0] cm;
    int sent, got, c;
    sent = 0; got = 0; c = 0; prev_stall = 1'b0; prev_ob = '0;
    exp_q.delete();
    cb = 8'($urandom); cs = 3'($urandom); cm = 2'($urandom);
    while (got < 10 && c < 60) begin
      ordy = !(c >= 5 && c <= 9);
      step(sent < 10, cb, cs, cm, ordy, ir, ov, ob);
      if (prev_stall) begin
        n_cmp++; if (ob !== prev_ob) begin n_err++; $display("FAIL stall_stable c=%0d got=%h exp=%h", c, ob, prev_ob); end
      end
      if (ov && !ordy) begin
        n_cmp++; if (ir !== 1'b0) begin n_err++; $display("FAIL stall_iready c=%0d got=%b exp=0", c, ir); end
      end
      if (ov && ordy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL stall_extra got=%h exp=none", ob); end
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (ob !== e) begin n_err++; $display("FAIL stall_data n=%0d got=%h exp=%h", got, ob, e); end
        end
        got++;
      end
      if (sent < 10 && ir) begin
        exp_q.push_back(ref_op(cb, int'(cs), cm));
        sent++;
        cb = 8'($urandom); cs = 3'($urandom); cm = 2'($urandom);
      end
      prev_stall = ov && !ordy;
      prev_ob = ob;
      c++;
    end
    n_cmp++; if (got != 10) begin n_err++; $display("FAIL stall_count got=%0d exp=10", got); end
  endtask

  task automatic test_reset_mid;
    logic ir, ov;
    logic [7:0] ob;
    step(1'b1, 8'hF0, 3'd1, 2'b00, 1'b1, ir, ov, ob);
    step(1'b1, 8'h0F, 3'd2, 2'b01, 1'b1, ir, ov, ob);
    @(negedge clk);
    rst = 1'b0; iValid = 1'b0;
    #1;
    n_cmp++; if (iReady !== 1'b0) begin n_err++; $display("FAIL midrst_iready got=%b exp=0", iReady); end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, ir, ov, ob);
      n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL midrst_ovalid c=%0d got=%b exp=0", c, ov); end
    end
  endtask

  task automatic test_random;
    logic ir, ov, ordy, v, prev_stall;
    logic [7:0] ob, prev_ob, cb;
    logic [2:0] cs;
    logic [1:0] cm;
    int sent, got, c;
    sent = 0; got = 0; c = 0; v = 1'b0; prev_stall = 1'b0; prev_ob = '0;
    exp_q.delete();
    cb = 8'($urandom); cs = 3'($urandom); cm = 2'($urandom);
    while (got < 10000 && c < 40000) begin
      // Once offered, an item is held until it is taken.
      if (!v) v = (sent < 10000) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      step(v, cb, cs, cm, ordy, ir, ov, ob);
      if (ir !== (!ov || ordy)) begin
        n_cmp++; n_err++; $display("FAIL rand_iready c=%0d got=%b ov=%b ordy=%b", c, ir, ov, ordy);
      end
      if (prev_stall && (ov !== 1'b1 || ob !== prev_ob)) begin
        n_cmp++; n_err++; $display("FAIL rand_hold c=%0d got=%b/%h exp=1/%h", c, ov, ob, prev_ob);
      end
      if (ov && ordy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rand_extra c=%0d got=%h exp=none", c, ob); end
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (ob !== e) begin n_err++; $display("FAIL rand_data n=%0d got=%h exp=%h", got, ob, e); end
        end
        got++;
      end
      if (v && ir) begin
        exp_q.push_back(ref_op(cb, int'(cs), cm));
        sent++;
        v = 1'b0;
        cb = 8'($urandom); cs = 3'($urandom); cm = 2'($urandom);
      end else if (!v) begin
        cb = 8'($urandom); cs = 3'($urandom); cm = 2'($urandom);
      end
      prev_stall = ov && !ordy;
      prev_ob = ob;
      c++;
    end
    n_cmp++; if (got != 10000) begin n_err++; $display("FAIL rand_count got=%0d exp=10000", got); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
- REQ-001: Parameter width, default 8; data width in bits; SHALL be a power of two, 2 to 64.
- REQ-002: Derived constant STAGES = clog2(width); this is the pipeline depth and latency.
- REQ-003: clk  in  1  rising-edge clock; the only clock.
- REQ-004: rst  in  1  reset, synchronous, active-low; sampled only on rising clk.
- REQ-005: iValid  in  1  input transfer request.
- REQ-006: iReady  out  1  input accepted when iValid=1 and iReady=1 at a rising clk.
- REQ-007: iBits  in  width  data to shift.
- REQ-008: shift  in  clog2(width)  shift amount, 0 to width-1.
- REQ-009: mode  in  2  00 logical right, 01 logical left, 10 arithmetic right, 11 rotate right.
- REQ-010: oValid  out  1  output holds a valid result.
- REQ-011: oReady  in  1  downstream accepts oBits when oValid=1 and oReady=1 at a rising clk.
- REQ-012: oBits  out  width  shifted result.

Function
- REQ-013: Stage k (0..STAGES-1) SHALL register data, valid, mode and remaining shift bits; it applies a shift of 2^k when shift bit k is 1, else passes data unchanged.
- REQ-014: Per-stage operation SHALL be as follows.
  - Logical right: zero-fill at MSB.
  - Logical left: zero-fill at LSB.
  - Arithmetic right: fill with the original iBits MSB, carried through the stages.
  - Rotate right: bits leaving at LSB re-enter at MSB.
- REQ-015: Final result SHALL equal the single-step operation on iBits by shift; shift=0 in any mode yields iBits unchanged.
- REQ-016: Latency SHALL be exactly STAGES cycles from the accepting edge to oValid=1 with the result, when not stalled.
- REQ-017: Throughput SHALL be one transfer per cycle while oReady=1.
- REQ-018: Advance enable adv = (not oValid) or oReady; all stage registers update only when adv=1.
- REQ-019: iReady SHALL equal adv (combinational) while rst=1.
- REQ-020: When adv=0, all stage registers including oBits/oValid SHALL hold; oBits SHALL remain stable while oValid=1 and oReady=0.
- REQ-021: When adv=1 and iValid=0, a bubble (valid=0) SHALL enter stage 0; data registers of bubbles are don't-care except at the output, where oBits SHALL hold its last value.
- REQ-022: An input offered while iReady=0 SHALL NOT be captured; the upstream must hold it.
- REQ-023: Simultaneous output transfer and input accept in the same cycle SHALL both occur with no loss or duplication.
- REQ-024: Results SHALL leave in acceptance order; no transfer is dropped, duplicated or reordered under any oReady pattern.
- REQ-025: mode and shift are sampled only at the accepting edge; later changes SHALL NOT affect in-flight items.

Reset
- REQ-026: While rst=0 at a rising clk: all stage valids, oValid and oBits SHALL be 0 at the next cycle; iReady SHALL be 0 while rst=0.
- REQ-027: Reset asserted mid-operation SHALL discard all in-flight items; no result from before reset appears afterwards.
- REQ-028: First accept SHALL be possible on the first rising clk with rst=1.

Verification (width=8, STAGES=3)
- REQ-029: Hold rst=0 for 2 cycles, then release.
  - During reset: oValid=0, oBits=0x00, iReady=0.
  - Cycle after release: iReady=1.
- REQ-030: Accept on consecutive edges with oReady=1: (0xB4, 3, 00), (0xB4, 3, 01), (0xB4, 3, 10), (0xB4, 3, 11).
  - Outputs on consecutive cycles starting 3 cycles after the first accept: 0x16, 0xA0, 0xF6, 0x96.
- REQ-031: Accept (0x81, 0, any mode) -> oBits=0x81 after 3 cycles; accept (0x80, 7, 10) -> 0xFF; accept (0x01, 7, 11) -> 0x02.
- REQ-032: Stream 10 items, oReady=0 for cycles 5-9.
  - oBits stable while stalled; iReady=0 once the output is valid and stalled.
  - All 10 results in order, none lost.
- REQ-033: Accept 2 items, assert rst=0 for 1 cycle before either emerges -> oValid stays 0 for the following 4 cycles.
- REQ-034: Random 10k-transfer run with random iValid/oReady against a reference model -> every result matches, order preserved, no duplicate.
